// File: rtl/line_fill_master_pkg.sv
// Shared types and constants for the I-cache line fill master.
package line_fill_master_pkg;

    // AHB transfer types.
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    // AHB burst types used by the fill master.
    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_WRAP4  = 3'b010
    } burst_type_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int unsigned BEATS_PER_LINE = 4;

    // Fill sequencer states.
    typedef enum logic [2:0] {
        FILL_IDLE,
        FILL_ADDR,
        FILL_BURST,
        FILL_LAST,
        FILL_DONE
    } fill_state_t;

    // Word index inside a 4-word line for beat n of a WRAP4 burst.
    function automatic logic [1:0] wrap_index(input logic [1:0] start_word,
                                              input logic [1:0] beat);
        return start_word + beat;
    endfunction

endpackage

// File: rtl/line_fill_master_wrap_addr_gen.sv
// WRAP4 beat address generator: keeps the line bits of the base address
// and advances the word index modulo 4.
module wrap_addr_gen
    import line_fill_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [1:0]            beat_idx,
    output logic [ADDR_WIDTH-1:0] beat_addr
);

    // Replace only the word-select bits; everything else comes from the base.
    always_comb begin
        beat_addr      = base_addr;
        beat_addr[3:2] = wrap_index(base_addr[3:2], beat_idx);
    end

endmodule

// File: rtl/line_fill_master.sv
// I-cache line fill master: turns one miss request into an AHB-lite WRAP4
// read burst, forwards the critical word and returns the assembled line.
module line_fill_master
    import line_fill_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  hclk,
    input  logic                  hrst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  crit_valid,
    output logic [DATA_WIDTH-1:0] crit_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [LINE_WIDTH-1:0] resp_line,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    if (LINE_WIDTH != BEATS_PER_LINE * DATA_WIDTH) begin : g_bad_line_width
        $error("line_fill_master: LINE_WIDTH must equal 4*DATA_WIDTH");
    end

    fill_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  err_pend_q, err_pend_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  resp_err_q, resp_err_d;
    logic                  crit_valid_q, crit_valid_d;
    logic [DATA_WIDTH-1:0] crit_data_q, crit_data_d;

    logic [1:0]            addr_idx;
    logic [1:0]            data_widx;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr[1:0];

    // In BURST the address phase runs one beat ahead of the data phase (cnt_q).
    assign addr_idx  = (state_q == FILL_BURST) ? cnt_q + 2'd1 : cnt_q;
    assign data_widx = wrap_index(base_q[3:2], cnt_q);

    wrap_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wrap_addr_gen (
        .base_addr (base_q),
        .beat_idx  (addr_idx),
        .beat_addr (beat_addr)
    );

    assign req_ready  = (state_q == FILL_IDLE);
    assign resp_valid = (state_q == FILL_DONE);
    assign resp_line  = line_q;
    assign resp_addr  = {base_q[ADDR_WIDTH-1:4], 4'b0000};
    assign resp_err   = resp_err_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
    assign hwrite     = 1'b0;
    assign hsize      = HSIZE_WORD;

    // Next-state, beat capture and AHB address-phase signalling.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        err_pend_d   = err_pend_q;
        line_d       = line_q;
        resp_err_d   = resp_err_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        haddr        = '0;
        htrans       = HTRANS_IDLE;
        hburst       = BURST_SINGLE;

        case (state_q)
            FILL_IDLE: begin
                if (req_valid) begin
                    base_d     = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    cnt_d      = 2'd0;
                    err_pend_d = 1'b0;
                    resp_err_d = 1'b0;
                    state_d    = FILL_ADDR;
                end
            end

            FILL_ADDR: begin
                haddr  = beat_addr;
                htrans = HTRANS_NONSEQ;
                hburst = BURST_WRAP4;
                if (hready) begin
                    state_d = FILL_BURST;
                end
            end

            FILL_BURST: begin
                haddr  = beat_addr;
                hburst = BURST_WRAP4;
                // After the first ERROR cycle the pending SEQ is withdrawn.
                htrans = err_pend_q ? HTRANS_IDLE : HTRANS_SEQ;
                if (hready) begin
                    if (hresp) begin
                        err_pend_d = 1'b0;
                        resp_err_d = 1'b1;
                        state_d    = FILL_DONE;
                    end else begin
                        line_d[32'(data_widx) * DATA_WIDTH +: DATA_WIDTH] = hrdata;
                        if (cnt_q == 2'd0) begin
                            crit_valid_d = 1'b1;
                            crit_data_d  = hrdata;
                        end
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd2) begin
                            state_d = FILL_LAST;
                        end
                    end
                end else if (hresp) begin
                    err_pend_d = 1'b1;
                end
            end

            FILL_LAST: begin
                haddr  = beat_addr;
                hburst = BURST_WRAP4;
                if (hready) begin
                    if (hresp) begin
                        resp_err_d = 1'b1;
                    end else begin
                        line_d[32'(data_widx) * DATA_WIDTH +: DATA_WIDTH] = hrdata;
                    end
                    err_pend_d = 1'b0;
                    state_d    = FILL_DONE;
                end
            end

            FILL_DONE: begin
                if (resp_ready) begin
                    state_d = FILL_IDLE;
                end
            end

            default: begin
                state_d = FILL_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q      <= FILL_IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            err_pend_q   <= 1'b0;
            line_q       <= '0;
            resp_err_q   <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            err_pend_q   <= err_pend_d;
            line_q       <= line_d;
            resp_err_q   <= resp_err_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
        end
    end

endmodule

// File: tb/tb_line_fill_master.sv
// Directed self-checking bench for line_fill_master.
module tb_line_fill_master;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_WRAP4  = 3'b010;

    logic         hclk, hrst;
    logic         req_valid, req_ready;
    logic [31:0]  req_addr;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         resp_valid, resp_ready;
    logic [127:0] resp_line;
    logic [31:0]  resp_addr;
    logic         resp_err;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize, hburst;
    logic [31:0]  hrdata;
    logic         hready, hresp;

    int checks = 0;
    int errors = 0;

    line_fill_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LINE_WIDTH (128)
    ) dut (
        .hclk       (hclk),
        .hrst       (hrst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_line  (resp_line),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hburst     (hburst),
        .hrdata     (hrdata),
        .hready     (hready),
        .hresp      (hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Stimulus-only zero-wait fill; returns in the DONE cycle.
    task automatic drive_fill(input logic [31:0] addr, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] d3);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        tick();
        hrdata = d0;
        tick();
        hrdata = d1;
        tick();
        hrdata = d2;
        tick();
        hrdata = d3;
        tick();
    endtask

    task automatic test_reset();
        hrst = 1'b1;
        tick();
        tick();
        hrst = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        checks++; if (htrans !== T_IDLE) begin errors++; $display("FAIL rst_htrans: got %b expected %b", htrans, T_IDLE); end
        checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL rst_haddr: got %h expected 0", haddr); end
        checks++; if (hburst !== B_SINGLE) begin errors++; $display("FAIL rst_hburst: got %b expected %b", hburst, B_SINGLE); end
        checks++; if ({crit_valid, resp_valid, resp_err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {crit_valid, resp_valid, resp_err}); end
        checks++; if (resp_line !== 128'h0) begin errors++; $display("FAIL rst_line: got %h expected 0", resp_line); end
        checks++; if (resp_addr !== 32'h0) begin errors++; $display("FAIL rst_resp_addr: got %h expected 0", resp_addr); end
        checks++; if (hwrite !== 1'b0) begin errors++; $display("FAIL rst_hwrite: got %b expected 0", hwrite); end
        checks++; if (hsize !== 3'b010) begin errors++; $display("FAIL rst_hsize: got %b expected 010", hsize); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] ea [4];
        ea = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
        req_valid = 1'b1;
        req_addr  = 32'h1008;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zw_req_ready: got %b expected 1", req_ready); end
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            checks++; if (htrans !== ((b == 0) ? T_NONSEQ : T_SEQ)) begin errors++; $display("FAIL zw_htrans beat %0d: got %b expected %b", b, htrans, (b == 0) ? T_NONSEQ : T_SEQ); end
            checks++; if (haddr !== ea[b]) begin errors++; $display("FAIL zw_haddr beat %0d: got %h expected %h", b, haddr, ea[b]); end
            if (b == 0) begin
                checks++; if (hburst !== B_WRAP4) begin errors++; $display("FAIL zw_hburst: got %b expected %b", hburst, B_WRAP4); end
            end
            if (b == 2) begin
                checks++; if ({crit_valid, crit_data} !== {1'b1, 32'h1008}) begin errors++; $display("FAIL zw_crit: got %b/%h expected 1/00001008", crit_valid, crit_data); end
            end
            if (b == 3) begin
                checks++; if (crit_valid !== 1'b0) begin errors++; $display("FAIL zw_crit_pulse: got %b expected 0", crit_valid); end
            end
            if (b > 0) hrdata = ea[b-1];
            tick();
        end
        checks++; if (htrans !== T_IDLE) begin errors++; $display("FAIL zw_htrans_last: got %b expected %b", htrans, T_IDLE); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL zw_resp_early: got %b expected 0", resp_valid); end
        hrdata = ea[3];
        tick();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL zw_resp_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_line !== 128'h0000100C_00001008_00001004_00001000) begin errors++; $display("FAIL zw_line: got %h expected 0000100c000010080000100400001000", resp_line); end
        checks++; if (resp_addr !== 32'h1000) begin errors++; $display("FAIL zw_resp_addr: got %h expected 00001000", resp_addr); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL zw_resp_err: got %b expected 0", resp_err); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL zw_handshake: got %b expected 01", {resp_valid, req_ready}); end
    endtask

    task automatic test_wait_states();
        logic [31:0] ea [4];
        ea = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
        req_valid = 1'b1;
        req_addr  = 32'h2000;
        tick();
        req_valid = 1'b0;
        checks++; if ({htrans, haddr} !== {T_NONSEQ, 32'h2000}) begin errors++; $display("FAIL ws_nonseq: got %b/%h expected 10/00002000", htrans, haddr); end
        tick();
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 3; w++) begin
                hready = (w == 2);
                hrdata = (w == 2) ? ea[b] : 32'hDEAD_BEEF;
                checks++; if (htrans !== ((b < 3) ? T_SEQ : T_IDLE)) begin errors++; $display("FAIL ws_htrans b%0d w%0d: got %b expected %b", b, w, htrans, (b < 3) ? T_SEQ : T_IDLE); end
                if (b < 3) begin
                    checks++; if (haddr !== ea[b+1]) begin errors++; $display("FAIL ws_haddr b%0d w%0d: got %h expected %h", b, w, haddr, ea[b+1]); end
                end
                if (b == 1 && w == 0) begin
                    checks++; if ({crit_valid, crit_data} !== {1'b1, 32'h2000}) begin errors++; $display("FAIL ws_crit: got %b/%h expected 1/00002000", crit_valid, crit_data); end
                end
                if (b == 3 && w == 2) begin
                    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ws_resp_early: got %b expected 0", resp_valid); end
                end
                tick();
            end
        end
        hready = 1'b1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL ws_resp_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_line !== 128'h0000200C_00002008_00002004_00002000) begin errors++; $display("FAIL ws_line: got %h expected 0000200c000020080000200400002000", resp_line); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_error();
        req_valid = 1'b1;
        req_addr  = 32'h3004;
        tick();
        req_valid = 1'b0;
        checks++; if ({htrans, haddr} !== {T_NONSEQ, 32'h3004}) begin errors++; $display("FAIL er_nonseq: got %b/%h expected 10/00003004", htrans, haddr); end
        tick();
        hrdata = 32'h3004;
        tick();
        checks++; if ({crit_valid, crit_data} !== {1'b1, 32'h3004}) begin errors++; $display("FAIL er_crit: got %b/%h expected 1/00003004", crit_valid, crit_data); end
        hrdata = 32'h3008;
        tick();
        checks++; if ({htrans, haddr} !== {T_SEQ, 32'h3000}) begin errors++; $display("FAIL er_seq3: got %b/%h expected 11/00003000", htrans, haddr); end
        hready = 1'b0;
        hresp  = 1'b1;
        tick();
        checks++; if (htrans !== T_IDLE) begin errors++; $display("FAIL er_cancel: got %b expected %b", htrans, T_IDLE); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL er_resp_early: got %b expected 0", resp_valid); end
        hready = 1'b1;
        tick();
        hresp = 1'b0;
        checks++; if ({resp_valid, resp_err} !== 2'b11) begin errors++; $display("FAIL er_resp: got %b expected 11", {resp_valid, resp_err}); end
        checks++; if (htrans !== T_IDLE) begin errors++; $display("FAIL er_no_4th: got %b expected %b", htrans, T_IDLE); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++; if ({htrans, req_ready, resp_valid} !== {T_IDLE, 2'b10}) begin errors++; $display("FAIL er_after: got %b expected 0010", {htrans, req_ready, resp_valid}); end
    endtask

    task automatic test_resp_hold();
        drive_fill(32'h6000, 32'h6000, 32'h6004, 32'h6008, 32'h600C);
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1;
            req_addr  = 32'h7000;
            checks++; if ({resp_valid, req_ready, htrans} !== {2'b10, T_IDLE}) begin errors++; $display("FAIL hold_flags c%0d: got %b expected 1000", c, {resp_valid, req_ready, htrans}); end
            checks++; if (resp_line !== 128'h0000600C_00006008_00006004_00006000) begin errors++; $display("FAIL hold_line c%0d: got %h expected 0000600c000060080000600400006000", c, resp_line); end
            checks++; if (resp_addr !== 32'h6000) begin errors++; $display("FAIL hold_addr c%0d: got %h expected 00006000", c, resp_addr); end
            tick();
        end
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hold_end: got %b expected 1", resp_valid); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++; if ({resp_valid, req_ready, htrans} !== {2'b01, T_IDLE}) begin errors++; $display("FAIL hold_release: got %b expected 0100", {resp_valid, req_ready, htrans}); end
    endtask

    task automatic test_reset_mid_burst();
        req_valid = 1'b1;
        req_addr  = 32'h8000;
        tick();
        req_valid = 1'b0;
        tick();
        hrdata = 32'h8000;
        tick();
        hrdata = 32'h8004;
        hrst   = 1'b1;
        tick();
        hrst = 1'b0;
        checks++; if ({htrans, resp_valid, req_ready, crit_valid} !== {T_IDLE, 3'b010}) begin errors++; $display("FAIL mrst_state: got %b expected 00010", {htrans, resp_valid, req_ready, crit_valid}); end
        drive_fill(32'h4000, 32'h4000, 32'h4004, 32'h4008, 32'h400C);
        checks++; if ({resp_valid, resp_err} !== 2'b10) begin errors++; $display("FAIL mrst_resp: got %b expected 10", {resp_valid, resp_err}); end
        checks++; if (resp_line !== 128'h0000400C_00004008_00004004_00004000) begin errors++; $display("FAIL mrst_line: got %h expected 0000400c000040080000400400004000", resp_line); end
        checks++; if (resp_addr !== 32'h4000) begin errors++; $display("FAIL mrst_addr: got %h expected 00004000", resp_addr); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive_fill(32'h5000, 32'h5000, 32'h5004, 32'h5008, 32'h500C);
        checks++; if (resp_line !== 128'h0000500C_00005008_00005004_00005000) begin errors++; $display("FAIL b2b_line1: got %h expected 0000500c000050080000500400005000", resp_line); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++; if ({req_ready, htrans} !== {1'b1, T_IDLE}) begin errors++; $display("FAIL b2b_idle: got %b expected 100", {req_ready, htrans}); end
        req_valid = 1'b1;
        req_addr  = 32'h500C;
        tick();
        req_valid = 1'b0;
        checks++; if ({htrans, haddr} !== {T_NONSEQ, 32'h500C}) begin errors++; $display("FAIL b2b_nonseq: got %b/%h expected 10/0000500c", htrans, haddr); end
        tick();
        checks++; if ({htrans, haddr} !== {T_SEQ, 32'h5000}) begin errors++; $display("FAIL b2b_seq1: got %b/%h expected 11/00005000", htrans, haddr); end
        hrdata = 32'h0000500C;
        tick();
        checks++; if ({crit_valid, crit_data} !== {1'b1, 32'h500C}) begin errors++; $display("FAIL b2b_crit: got %b/%h expected 1/0000500c", crit_valid, crit_data); end
        hrdata = 32'h00015000;
        tick();
        hrdata = 32'h00015004;
        tick();
        hrdata = 32'h00015008;
        tick();
        checks++; if ({resp_valid, resp_err} !== 2'b10) begin errors++; $display("FAIL b2b_resp2: got %b expected 10", {resp_valid, resp_err}); end
        checks++; if (resp_line !== 128'h0000500C_00015008_00015004_00015000) begin errors++; $display("FAIL b2b_line2: got %h expected 0000500c000150080001500400015000", resp_line); end
        checks++; if (resp_addr !== 32'h5000) begin errors++; $display("FAIL b2b_addr2: got %h expected 00005000", resp_addr); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        hrst       = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        resp_ready = 1'b0;
        hrdata     = 32'h0;
        hready     = 1'b1;
        hresp      = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_error();
        test_resp_hold();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
